// File: rtl/add_scheduler.sv
// add_scheduler: round-robin two-requester adder, one 4-bit slice per RUN cycle.
// Define ADD_SCHED_EARLY_EN to finish early when remaining slices and carry are all zero.
module add_scheduler #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       req,
   input  logic [WIDTH-1:0] a0,
   input  logic [WIDTH-1:0] b0,
   input  logic [WIDTH-1:0] a1,
   input  logic [WIDTH-1:0] b1,
   input  logic             c_in0,
   input  logic             c_in1,
   output logic             busy,
   output logic             owner,
   output logic [1:0]       done,
   output logic [WIDTH-1:0] sum,
   output logic             c_out
);
   localparam int NSLICE = WIDTH / 4;
   localparam int KW = $clog2(NSLICE);
   localparam int BW = KW + 2;
   localparam logic [KW-1:0] KLAST = KW'(NSLICE - 1);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, state_nx;
   logic [KW-1:0] k;
   logic [BW-1:0] base;
   logic carry, last, gnt, fin, cout_nx;
   logic [WIDTH-1:0] a_lat, b_lat, acc, acc_nx, res;
   logic [4:0] s5;
   assign gnt = req == 2'b11 ? ~last : req[1];
   assign busy = state != IDLE;
   assign done = state == DONE ? (owner ? 2'b10 : 2'b01) : 2'b00;
   always_comb begin
      base = {k, 2'b00};
      s5 = {1'b0, a_lat[base +: 4]} + {1'b0, b_lat[base +: 4]} + {4'b0, carry};
      acc_nx = acc;
      acc_nx[base +: 4] = s5[3:0];
`ifdef ADD_SCHED_EARLY_EN
      // nothing left to add above slice k: clear the upper result and stop now
      fin = k == KLAST || (k != '0 && !carry && ((a_lat | b_lat) >> base) == '0);
      res = (k != '0 && !carry && ((a_lat | b_lat) >> base) == '0) ? acc & ~({WIDTH{1'b1}} << base) : acc_nx;
      cout_nx = k == KLAST && res == acc_nx ? s5[4] : 1'b0;
`else
      fin = k == KLAST;
      res = acc_nx;
      cout_nx = s5[4];
`endif
   end
   always_comb
      state_nx = state == IDLE ? (req != 2'b00 ? RUN : IDLE) :
                 state == RUN  ? (fin ? DONE : RUN) : IDLE;
   always_ff @(posedge clk)
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   always_ff @(posedge clk)
      if (!rst_n) begin
         k <= '0;
         carry <= 1'b0;
         last <= 1'b1;
         owner <= 1'b0;
         sum <= '0;
         c_out <= 1'b0;
         a_lat <= '0;
         b_lat <= '0;
         acc <= '0;
      end else if (state == IDLE && req != 2'b00) begin
         owner <= gnt;
         a_lat <= gnt ? a1 : a0;
         b_lat <= gnt ? b1 : b0;
         carry <= gnt ? c_in1 : c_in0;
         k <= '0;
      end else if (state == RUN) begin
         acc <= res;
         carry <= s5[4];
         k <= k + 1'b1;
         if (fin) begin
            sum <= res;
            c_out <= cout_nx;
         end
      end else if (state == DONE) last <= owner;
endmodule
